// File: rtl/uio_bus_sequencer.sv
// -----------------------------------------------------------------------------
// uio_bus_sequencer
//
// Shares one byte-wide external memory bus between the CPU's instruction-fetch
// port and its data port. Each 32-bit access is sent as a byte-serial frame:
// a command byte, three address bytes, and then one of two tails:
//   - writes: four write-data bytes, LSB first;
//   - reads:  a turnaround cycle, then four read-data bytes. The external
//             device may stall each read byte with wait states.
//
// Ports
//   clk, rst              : single clock; synchronous active-high reset
//   i_valid/i_addr        : fetch request (always a read, all strobes set)
//   i_ready/i_rdata/i_err : one-cycle fetch completion with held data/error
//   d_valid/d_we/d_addr/d_wdata/d_strb : data request
//   d_ready/d_rdata/d_err : one-cycle data completion with held data/error
//   ext_dout/ext_oe       : bus byte driven by this block and its enable
//   ext_din/ext_ready     : bus byte from the device and its valid flag
//   ext_frame             : a transaction is occupying the bus
//   busy                  : sequencer is not idle
// -----------------------------------------------------------------------------
module uio_bus_sequencer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_valid,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_strb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [7:0]  ext_dout,
  output logic        ext_oe,
  input  logic [7:0]  ext_din,
  input  logic        ext_ready,
  output logic        ext_frame,
  output logic        busy
);

  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR0, ADDR1, ADDR2,
    WDATA0, WDATA1, WDATA2, WDATA3,
    TURN, RDATA0, RDATA1, RDATA2, RDATA3,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;   // 1 = data port owns the transaction
  logic        last_q;             // port granted most recently, 1 = data
  logic [23:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [23:0] rbuf_q;             // bytes 0..2; byte 3 goes straight out
  logic [7:0]  wcnt_q;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic        i_err_q, d_err_q;
  logic        advance;
  logic        timeout;
  logic [31:0] finalWord;

  // Address bits 31:24 never reach the bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:24], d_addr[31:24]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. On a tie, the port that did not win last time gets the
  // bus. A read byte either arrives (advance) or burns one wait cycle. Once
  // the wait count has reached WAIT_MAX, one more stall aborts the read.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    advance = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid || d_valid) begin
          state_d = CMD;
          grant_d = (i_valid && d_valid) ? ~last_q : d_valid;
        end
      end
      CMD:    state_d = ADDR0;
      ADDR0:  state_d = ADDR1;
      ADDR1:  state_d = ADDR2;
      ADDR2:  state_d = we_q ? WDATA0 : TURN;
      WDATA0: state_d = WDATA1;
      WDATA1: state_d = WDATA2;
      WDATA2: state_d = WDATA3;
      WDATA3: state_d = DONE;
      TURN:   state_d = RDATA0;
      RDATA0, RDATA1, RDATA2, RDATA3: begin
        if (ext_ready) begin
          advance = 1'b1;
          case (state_q)
            RDATA0:  state_d = RDATA1;
            RDATA1:  state_d = RDATA2;
            RDATA2:  state_d = RDATA3;
            default: state_d = DONE;
          endcase
        end else if (wcnt_q == WaitMax) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign finalWord = timeout ? 32'hFFFF_FFFF : {ext_din, rbuf_q};

  // Transaction payload, read assembly, wait counter and the per-port result
  // registers. The payload is frozen at grant so that requester changes made
  // mid-transaction cannot corrupt the frame. Results are loaded on the way
  // into DONE, so they are already valid during the ready pulse and then
  // hold until the next completion on that port.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q   <= 1'b0;
      last_q    <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rbuf_q    <= '0;
      wcnt_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d == CMD) begin
        grant_q <= grant_d;
        last_q  <= grant_d;
        addr_q  <= grant_d ? d_addr[23:0] : i_addr[23:0];
        we_q    <= grant_d & d_we;
        wdata_q <= grant_d ? d_wdata : 32'h0;
        strb_q  <= grant_d ? d_strb : 4'hF;
        rbuf_q  <= '0;
      end

      if (advance) begin
        case (state_q)
          RDATA0:  rbuf_q[7:0]   <= ext_din;
          RDATA1:  rbuf_q[15:8]  <= ext_din;
          RDATA2:  rbuf_q[23:16] <= ext_din;
          default: ;
        endcase
      end

      if (state_q == IDLE || advance) begin
        wcnt_q <= '0;
      end else if (state_q inside {RDATA0, RDATA1, RDATA2, RDATA3}) begin
        wcnt_q <= wcnt_q + 8'd1;
      end

      if (state_d == DONE && state_q != DONE) begin
        if (grant_q) begin
          d_err_q <= timeout;
          if (!we_q) begin
            d_rdata_q <= finalWord;
          end
        end else begin
          i_err_q   <= timeout;
          i_rdata_q <= finalWord;
        end
      end
    end
  end

  // Output decode, purely from registered state so nothing combinational
  // leaks from the inputs to the pins.
  always_comb begin
    ext_dout  = 8'h00;
    ext_oe    = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    ext_frame = (state_q != IDLE) && (state_q != DONE);
    busy      = (state_q != IDLE);
    case (state_q)
      CMD: begin
        ext_dout = {we_q, 3'b000, strb_q};
        ext_oe   = 1'b1;
      end
      ADDR0:  begin ext_dout = addr_q[7:0];    ext_oe = 1'b1; end
      ADDR1:  begin ext_dout = addr_q[15:8];   ext_oe = 1'b1; end
      ADDR2:  begin ext_dout = addr_q[23:16];  ext_oe = 1'b1; end
      WDATA0: begin ext_dout = wdata_q[7:0];   ext_oe = 1'b1; end
      WDATA1: begin ext_dout = wdata_q[15:8];  ext_oe = 1'b1; end
      WDATA2: begin ext_dout = wdata_q[23:16]; ext_oe = 1'b1; end
      WDATA3: begin ext_dout = wdata_q[31:24]; ext_oe = 1'b1; end
      DONE: begin
        i_ready = ~grant_q;
        d_ready = grant_q;
      end
      default: ;
    endcase
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_err   = i_err_q;
  assign d_err   = d_err_q;

endmodule

// File: tb/tb_uio_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uio_bus_sequencer
//
// Bench for uio_bus_sequencer, built with WAIT_MAX = 4.
//
// Each scenario task drives requests and queues what it expects:
//   - busQ holds every byte that must appear on the bus while ext_oe is high;
//   - expQ holds every completion (port, data, error, cycle).
// A negedge monitor pops both queues as the DUT produces output. A small
// device model replays the read bytes and wait states that each task
// scheduled, keyed by absolute cycle number.
// -----------------------------------------------------------------------------
module tb_uio_bus_sequencer;

  localparam int unsigned WAIT_MAX = 4;

  typedef struct {
    bit          isData;
    bit          chkData;
    logic [31:0] rdata;
    bit          err;
    int          cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_valid;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_strb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [7:0]  ext_dout;
  logic        ext_oe;
  logic [7:0]  ext_din = 8'h00;
  logic        ext_ready = 1'b0;
  logic        ext_frame;
  logic        busy;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   readyCount = 0;
  bit   monEn = 1'b0;
  exp_t expQ[$];
  logic [7:0] busQ[$];
  bit         readyPlan[int];
  logic [7:0] dinPlan[int];
  exp_t       monExp;
  logic [7:0] monByte;
  logic [31:0] monData;

  uio_bus_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_strb(d_strb),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .ext_dout(ext_dout), .ext_oe(ext_oe), .ext_din(ext_din), .ext_ready(ext_ready),
    .ext_frame(ext_frame), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // External device: presents a read byte only in the cycles a task planned.
  always @(negedge clk) begin
    if (readyPlan.exists(cyc)) begin
      ext_ready = 1'b1;
      ext_din   = dinPlan[cyc];
    end else begin
      ext_ready = 1'b0;
      ext_din   = 8'h00;
    end
  end

  // Scoreboard monitor: bus bytes against busQ, completions against expQ.
  always @(negedge clk) begin
    if (monEn) begin
      tests++;
      if (ext_oe === 1'b1) begin
        if (busQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL bus_byte: drove %h at cycle %0d, required no drive", ext_dout, cyc);
        end else begin
          monByte = busQ.pop_front();
          if (ext_dout !== monByte) begin
            fails++;
            $display("[TB] FAIL bus_byte: got %h at cycle %0d, required %h", ext_dout, cyc, monByte);
          end
        end
      end else if (ext_oe !== 1'b0 || ext_dout !== 8'h00) begin
        fails++;
        $display("[TB] FAIL bus_idle: oe=%b dout=%h at cycle %0d, required oe=0 dout=00", ext_oe, ext_dout, cyc);
      end

      if (i_ready === 1'b1 || d_ready === 1'b1) begin
        readyCount++;
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_ready: i_ready=%b d_ready=%b at cycle %0d, required none", i_ready, d_ready, cyc);
        end else begin
          monExp = expQ.pop_front();
          monData = monExp.isData ? d_rdata : i_rdata;
          if ({i_ready, d_ready} !== {~monExp.isData, monExp.isData}) begin
            fails++;
            $display("[TB] FAIL grant_port: i_ready=%b d_ready=%b, required data=%b", i_ready, d_ready, monExp.isData);
          end else if (cyc !== monExp.cycle) begin
            fails++;
            $display("[TB] FAIL ready_cycle: got %0d, required %0d", cyc, monExp.cycle);
          end else if ((monExp.isData ? d_err : i_err) !== monExp.err) begin
            fails++;
            $display("[TB] FAIL err_flag: got %b, required %b", monExp.isData ? d_err : i_err, monExp.err);
          end else if (monExp.chkData && monData !== monExp.rdata) begin
            fails++;
            $display("[TB] FAIL rdata: got %h, required %h", monData, monExp.rdata);
          end
        end
      end
    end
  end

  task automatic plan_read(input int first, input logic [31:0] word, input int waitByte, input int waits);
    int t;
    t = first;
    for (int b = 0; b < 4; b++) begin
      if (b == waitByte) t += waits;
      readyPlan[t] = 1'b1;
      dinPlan[t]   = word[8*b +: 8];
      t++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_strb = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({i_ready, d_ready, i_err, d_err, ext_oe, ext_frame, busy} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b, required 0000000",
               {i_ready, d_ready, i_err, d_err, ext_oe, ext_frame, busy});
    end
    tests++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || ext_dout !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_data: i_rdata=%h d_rdata=%h dout=%h, required all 0", i_rdata, d_rdata, ext_dout);
    end
    rst = 1'b0;
    monEn = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_data_write();
    int c;
    logic [7:0] bytes [8] = '{8'h83, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    @(negedge clk);
    c = cyc;
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h0012_3456; d_wdata = 32'hDEAD_BEEF; d_strb = 4'b0011;
    foreach (bytes[k]) busQ.push_back(bytes[k]);
    expQ.push_back('{1'b1, 1'b0, 32'h0, 1'b0, c + 9});
    for (int k = 0; k < 40 && expQ.size() != 0; k++) begin
      @(negedge clk);
      if (d_ready === 1'b1) d_valid = 1'b0;
    end
    d_valid = 1'b0;
    tests++;
    if (expQ.size() != 0 || busQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL write_done: %0d completions and %0d bytes outstanding, required 0", expQ.size(), busQ.size());
      expQ.delete(); busQ.delete();
    end
  endtask

  task automatic test_fetch_read();
    int c;
    @(negedge clk);
    c = cyc;
    i_valid = 1'b1; i_addr = 32'h0000_0100;
    busQ.push_back(8'h0F); busQ.push_back(8'h00); busQ.push_back(8'h01); busQ.push_back(8'h00);
    plan_read(c + 6, 32'h1234_5678, 4, 0);
    expQ.push_back('{1'b0, 1'b1, 32'h1234_5678, 1'b0, c + 10});
    for (int k = 0; k < 40 && expQ.size() != 0; k++) begin
      @(negedge clk);
      // Requester drops valid early; the transaction must still finish.
      if (cyc == c + 2) i_valid = 1'b0;
      if (cyc == c + 5) begin
        tests++;
        if (ext_oe !== 1'b0 || ext_frame !== 1'b1) begin
          fails++;
          $display("[TB] FAIL turnaround: oe=%b frame=%b, required oe=0 frame=1", ext_oe, ext_frame);
        end
      end
    end
    i_valid = 1'b0;
    tests++;
    if (expQ.size() != 0 || busQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL fetch_done: %0d completions and %0d bytes outstanding, required 0", expQ.size(), busQ.size());
      expQ.delete(); busQ.delete();
    end
  endtask

  task automatic test_wait_states();
    int c;
    @(negedge clk);
    c = cyc;
    i_valid = 1'b1; i_addr = 32'h0000_0100;
    busQ.push_back(8'h0F); busQ.push_back(8'h00); busQ.push_back(8'h01); busQ.push_back(8'h00);
    plan_read(c + 6, 32'h1234_5678, 1, 3);
    expQ.push_back('{1'b0, 1'b1, 32'h1234_5678, 1'b0, c + 13});
    for (int k = 0; k < 40 && expQ.size() != 0; k++) begin
      @(negedge clk);
      if (i_ready === 1'b1) i_valid = 1'b0;
    end
    i_valid = 1'b0;
    tests++;
    if (expQ.size() != 0 || busQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL wait_done: %0d completions and %0d bytes outstanding, required 0", expQ.size(), busQ.size());
      expQ.delete(); busQ.delete();
    end
  endtask

  task automatic test_timeout();
    int c;
    @(negedge clk);
    c = cyc;
    d_valid = 1'b1; d_we = 1'b0; d_addr = 32'hAB00_0010; d_strb = 4'b1111;
    busQ.push_back(8'h0F); busQ.push_back(8'h10); busQ.push_back(8'h00); busQ.push_back(8'h00);
    expQ.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, c + 6 + int'(WAIT_MAX) + 1});
    for (int k = 0; k < 40 && expQ.size() != 0; k++) begin
      @(negedge clk);
      if (d_ready === 1'b1) d_valid = 1'b0;
    end
    d_valid = 1'b0;
    tests++;
    if (expQ.size() != 0 || busQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL timeout_done: %0d completions and %0d bytes outstanding, required 0", expQ.size(), busQ.size());
      expQ.delete(); busQ.delete();
    end
    tests++;
    if (i_rdata !== 32'h1234_5678 || i_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL fetch_hold: i_rdata=%h i_err=%b, required 12345678 0", i_rdata, i_err);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int dCount;
    logic [7:0] wr [8] = '{8'h8A, 8'h0B, 8'h0A, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0] rd [4] = '{8'h0F, 8'h00, 8'h20, 8'h00};
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c = cyc;
    dCount = 0;
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0A0B; d_wdata = 32'h1122_3344; d_strb = 4'b1010;
    i_valid = 1'b1; i_addr = 32'h0000_2000;
    foreach (wr[k]) busQ.push_back(wr[k]);
    foreach (rd[k]) busQ.push_back(rd[k]);
    foreach (wr[k]) busQ.push_back(wr[k]);
    expQ.push_back('{1'b1, 1'b0, 32'h0, 1'b0, c + 9});
    plan_read(c + 16, 32'hCAFE_F00D, 4, 0);
    expQ.push_back('{1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, c + 20});
    expQ.push_back('{1'b1, 1'b0, 32'h0, 1'b0, c + 30});
    for (int k = 0; k < 80 && expQ.size() != 0; k++) begin
      @(negedge clk);
      if (cyc == c + 9 || cyc == c + 10) begin
        tests++;
        if (ext_frame !== 1'b0 || ext_oe !== 1'b0) begin
          fails++;
          $display("[TB] FAIL bus_gap: frame=%b oe=%b at cycle %0d, required 0 0", ext_frame, ext_oe, cyc - c);
        end
      end
      if (d_ready === 1'b1) dCount++;
      if (dCount == 2) begin
        d_valid = 1'b0;
        i_valid = 1'b0;
      end
    end
    d_valid = 1'b0;
    i_valid = 1'b0;
    tests++;
    if (expQ.size() != 0 || busQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL arbitration_done: %0d completions and %0d bytes outstanding, required 0", expQ.size(), busQ.size());
      expQ.delete(); busQ.delete();
    end
  endtask

  task automatic test_reset_abort();
    int c;
    int r0;
    logic [7:0] bytes [7] = '{8'h83, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD};
    repeat (2) @(negedge clk);
    c = cyc;
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h0012_3456; d_wdata = 32'hDEAD_BEEF; d_strb = 4'b0011;
    foreach (bytes[k]) busQ.push_back(bytes[k]);
    for (int k = 0; k < 20 && cyc < c + 7; k++) @(negedge clk);
    rst = 1'b1;
    d_valid = 1'b0;
    r0 = readyCount;
    @(negedge clk);
    tests++;
    if ({ext_oe, ext_frame, busy} !== 3'b000 || ext_dout !== 8'h00) begin
      fails++;
      $display("[TB] FAIL abort_release: oe=%b frame=%b busy=%b dout=%h, required all 0", ext_oe, ext_frame, busy, ext_dout);
    end
    tests++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || i_err !== 1'b0 || d_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_clear: i_rdata=%h d_rdata=%h i_err=%b d_err=%b, required all 0", i_rdata, d_rdata, i_err, d_err);
    end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    tests++;
    if (readyCount != r0) begin
      fails++;
      $display("[TB] FAIL abort_no_ready: got %0d pulses, required 0", readyCount - r0);
    end
    tests++;
    if (busQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL abort_bytes: %0d bytes outstanding, required 0", busQ.size());
      busQ.delete();
    end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_fetch_read();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uio_bus_sequencer.md
# uio_bus_sequencer

Arbitrates the CPU's instruction-fetch and data-memory ports onto one shared 8-bit external memory bus, carried on the chip's bidirectional `uio` pins. Each 32-bit access becomes a byte-serial transaction: command, address, then data, with a bus turnaround and wait states on reads. The block sits between the CPU core and the top-level pin wrapper. The wrapper connects `ext_dout`/`ext_oe`/`ext_din` to `uio_out`/`uio_oe`/`uio_in`, and `ext_frame`/`ext_ready` to dedicated pins.

## Interface
- `WAIT_MAX`, 15: maximum consecutive `ext_ready`-low cycles tolerated in one read byte before abort (1..255).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: fetch request.
- `i_addr` in 32: fetch address.
- `i_ready` out 1: one-cycle completion pulse for fetch.
- `i_rdata` out 32: fetched word, valid with `i_ready`.
- `i_err` out 1: fetch timed out, valid with `i_ready`.
- `d_valid` in 1: data request.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in 32: data address.
- `d_wdata` in 32: write data.
- `d_strb` in 4: byte strobes, forwarded unchanged.
- `d_ready` out 1: one-cycle completion pulse for data.
- `d_rdata` out 32: read data, valid with `d_ready`.
- `d_err` out 1: data read timed out, valid with `d_ready`.
- `ext_dout` out 8: bus byte out.
- `ext_oe` out 1: bus drive enable (1 = block drives).
- `ext_din` in 8: bus byte in.
- `ext_ready` in 1: external device presents a valid read byte.
- `ext_frame` out 1: transaction in progress.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, CMD, ADDR0, ADDR1, ADDR2, WDATA0..WDATA3, TURN, RDATA0..RDATA3, DONE.
- **Arbitration in IDLE:**
  - If only one port is valid, grant it.
  - If both are valid, grant the port not granted last.
  - The `last` register resets to "fetch", so data wins the first tie.
- **Latching on the IDLE→CMD edge:** addr, we, wdata and strb are captured from the granted port.
  - Fetch forces we=0 and strb=4'hF.
  - Later changes to the payload are ignored.
- **Requester rule:** hold valid and payload until the ready pulse.
  - If valid drops mid-transaction, the transaction still completes and the ready pulse is still issued.
- **Bus bytes (`ext_dout`):**
  - CMD: {we, 3'b000, strb}.
  - ADDR0/1/2: addr[7:0], addr[15:8], addr[23:16]. addr[31:24] is discarded.
  - WDATAk: wdata[8k+7:8k], LSB first.
  - All other states: 8'h00.
- **`ext_oe`:** 1 in CMD, ADDR*, WDATA*; 0 otherwise.
- **`ext_frame`:** 1 from CMD through the last WDATA3/RDATA3 cycle; 0 in IDLE, TURN... no: 1 in TURN as well; 0 only in IDLE and DONE.
- **Transitions:**
  - IDLE→CMD→ADDR0→ADDR1→ADDR2.
  - Write path: ADDR2→WDATA0…WDATA3→DONE.
  - Read path: ADDR2→TURN→RDATA0.
  - RDATAk: if `ext_ready`=1, capture `ext_din` into rdata byte k and advance (RDATA3→DONE). Otherwise stay and increment the wait counter.
- **Wait counter:** 8 bits, cleared on each byte advance.
  - If it reaches `WAIT_MAX` while `ext_ready`=0, go to DONE with err=1 and rdata=32'hFFFF_FFFF.
- **DONE:** one-cycle ready pulse plus err on the granted port only, then IDLE.
  - Writes always complete with err=0.
- **Hold:** `i_rdata`/`d_rdata`/err are registered and hold their value until that port's next completion.
- **Reset (including mid-transaction):**
  - State IDLE; `last`=fetch.
  - All outputs 0: rdata 0, err 0, ready 0, oe 0, frame 0, dout 0, busy 0.
  - The aborted transaction receives no ready pulse.

## Timing
- All outputs are registered and decoded from the state register. No input-to-output combinational paths.
- Request sampled valid in IDLE at cycle N:
  - CMD on the bus at N+1.
  - Addresses at N+2..N+4.
- **Write:** data at N+5..N+8; ready pulse at N+9; IDLE at N+10; 10 cycles total.
- **Read, zero waits:** TURN at N+5; bytes captured at N+6..N+9; ready at N+10. Each wait cycle adds one.
- **Timeout:** DONE follows the cycle in which the counter equals `WAIT_MAX`.
- **Back-to-back:** the earliest next CMD is 2 cycles after DONE (DONE, then IDLE sampling).
- Bus idle between transactions: frame=0 and oe=0 for at least 2 cycles.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs 0, `busy`=0.
- **Data write:** write addr 32'h0012_3456, wdata 32'hDEAD_BEEF, strb 4'b0011.
  - Required bus sequence, one byte per cycle: 8'h83, 56, 34, 12, EF, BE, AD, DE.
  - `d_ready` at N+9, `d_err`=0.
- **Fetch read, no waits:** addr 32'h0000_0100, external bytes 78, 56, 34, 12.
  - Required bus: CMD 8'h0F, oe drops at TURN.
  - `i_rdata`=32'h1234_5678 with `i_ready` at N+10.
- **Wait states:** as the fetch-read case, with `ext_ready` low for 3 cycles in RDATA1 → `i_ready` at N+13, same data.
- **Timeout:** `WAIT_MAX`=4, `ext_ready` held low in RDATA0 → `d_ready` with `d_err`=1 and `d_rdata`=32'hFFFF_FFFF.
- **Arbitration and reset:**
  - Both ports valid continuously → grants alternate data, fetch, data.
  - `rst` asserted in WDATA2 → bus released next cycle and no `d_ready` pulse.
